// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
// Launches one req/ack transaction per legal EX/MEM access and stalls the
// front of the pipeline until it completes or times out.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_ins_valid,
   input  logic        ex_mem_memread,
   input  logic        ex_mem_memwrite,
   input  logic [2:0]  ex_mem_funct3,
   input  logic [31:0] ex_mem_aluout,
   input  logic [31:0] ex_mem_store_data,
   output logic [31:0] aluout1,
   output logic [31:0] aluout2,
   output logic        mem_ins_valid,
   output logic        mem_stall,
   output logic        mem_fault,
   output logic        bus_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   localparam int unsigned CNT_W = 10;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_cap;
   logic             r_bus_err;
   logic             r_req;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_be;

   logic             w_access;
   logic             w_legal_f3;
   logic             w_misaligned;
   logic             w_fault;
   logic             w_go;
   logic             w_tmo_hit;
   logic [31:0]      w_st_wdata;
   logic [3:0]       w_st_be;
   logic [7:0]       w_ld_byte;
   logic [15:0]      w_ld_half;
   logic [31:0]      w_ld_data;

   // Access decode: legality of funct3 and natural alignment
   always_comb begin
      w_access     = ex_mem_ins_valid & (ex_mem_memread | ex_mem_memwrite);
      w_legal_f3   = 1'b0;
      w_misaligned = 1'b0;
      if (ex_mem_memread) begin
         case (ex_mem_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal_f3 = 1'b1;
            default:                                w_legal_f3 = 1'b0;
         endcase
      end else begin
         case (ex_mem_funct3)
            3'b000, 3'b001, 3'b010: w_legal_f3 = 1'b1;
            default:                w_legal_f3 = 1'b0;
         endcase
      end
      case (ex_mem_funct3[1:0])
         2'b01:   w_misaligned = ex_mem_aluout[0];
         2'b10:   w_misaligned = |ex_mem_aluout[1:0];
         default: w_misaligned = 1'b0;
      endcase
      w_fault   = w_access & (~w_legal_f3 | w_misaligned);
      w_go      = w_access & ~w_fault;
      w_tmo_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
   end

   // Store lane replication and byte enables
   always_comb begin
      w_st_wdata = ex_mem_store_data;
      w_st_be    = 4'b1111;
      case (ex_mem_funct3[1:0])
         2'b00: begin
            w_st_wdata = {4{ex_mem_store_data[7:0]}};
            w_st_be    = 4'b0001 << ex_mem_aluout[1:0];
         end
         2'b01: begin
            w_st_wdata = {2{ex_mem_store_data[15:0]}};
            w_st_be    = 4'b0011 << {ex_mem_aluout[1], 1'b0};
         end
         default: ;
      endcase
   end

   // Load lane selection and sign/zero extension
   always_comb begin
      case (ex_mem_aluout[1:0])
         2'b00:   w_ld_byte = dmem_rdata[7:0];
         2'b01:   w_ld_byte = dmem_rdata[15:8];
         2'b10:   w_ld_byte = dmem_rdata[23:16];
         default: w_ld_byte = dmem_rdata[31:24];
      endcase
      w_ld_half = ex_mem_aluout[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (ex_mem_funct3)
         3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'b100:  w_ld_data = {24'd0, w_ld_byte};
         3'b101:  w_ld_data = {16'd0, w_ld_half};
         default: w_ld_data = dmem_rdata;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Next-state logic; ack outside REQ is never looked at
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_next = S_REQ;
         S_REQ:   if (dmem_ack || w_tmo_hit) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Bus launch, timeout counter and load-data capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_cap     <= '0;
         r_bus_err <= 1'b0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_req   <= 1'b1;
                  r_we    <= ex_mem_memwrite & ~ex_mem_memread;
                  r_addr  <= {ex_mem_aluout[31:2], 2'b00};
                  r_wdata <= w_st_wdata;
                  r_be    <= w_st_be;
                  r_cnt   <= '0;
               end
            end
            S_REQ: begin
               if (dmem_ack) begin
                  r_req <= 1'b0;
                  r_we  <= 1'b0;
                  r_cap <= ex_mem_memread ? w_ld_data : 32'd0;
               end else if (w_tmo_hit) begin
                  r_req     <= 1'b0;
                  r_we      <= 1'b0;
                  r_cap     <= '0;
                  r_bus_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Pipeline-facing outputs; all forced low while reset is asserted
   always_comb begin
      aluout1       = rst ? ex_mem_aluout : 32'd0;
      aluout2       = (rst && r_state == S_DONE) ? r_cap : 32'd0;
      mem_fault     = rst & w_fault;
      mem_stall     = rst & (((r_state == S_IDLE) & w_go) | (r_state == S_REQ));
      mem_ins_valid = rst & ex_mem_ins_valid & ~w_fault &
                      ~((r_state == S_DONE) & r_bus_err);
      bus_err       = r_bus_err;
      dmem_req      = r_req;
      dmem_we       = r_we;
      dmem_addr     = r_addr;
      dmem_wdata    = r_wdata;
      dmem_be       = r_be;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mem_ins_valid;
   logic        ex_mem_memread;
   logic        ex_mem_memwrite;
   logic [2:0]  ex_mem_funct3;
   logic [31:0] ex_mem_aluout;
   logic [31:0] ex_mem_store_data;
   logic [31:0] aluout1;
   logic [31:0] aluout2;
   logic        mem_ins_valid;
   logic        mem_stall;
   logic        mem_fault;
   logic        bus_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .ex_mem_ins_valid  (ex_mem_ins_valid),
      .ex_mem_memread    (ex_mem_memread),
      .ex_mem_memwrite   (ex_mem_memwrite),
      .ex_mem_funct3     (ex_mem_funct3),
      .ex_mem_aluout     (ex_mem_aluout),
      .ex_mem_store_data (ex_mem_store_data),
      .aluout1           (aluout1),
      .aluout2           (aluout2),
      .mem_ins_valid     (mem_ins_valid),
      .mem_stall         (mem_stall),
      .mem_fault         (mem_fault),
      .bus_err           (bus_err),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_be           (dmem_be),
      .dmem_ack          (dmem_ack),
      .dmem_rdata        (dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one memory instruction from IDLE through DONE, then retire it.
   // ack_k < 0 means never acknowledge.
   task automatic do_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input int ack_k,
                            input logic [31:0] rdata, input logic [31:0] exp_a2,
                            input logic [3:0] exp_be, input logic [31:0] exp_addr,
                            input logic exp_we, input logic chk_wd,
                            input logic [31:0] exp_wd, input int exp_stalls,
                            input int exp_reqs, input logic exp_berr,
                            input logic exp_valid);
      int  stalls = 0;
      int  reqs   = 0;
      bit  done   = 1'b0;
      ex_mem_ins_valid  = 1'b1;
      ex_mem_memread    = rd;
      ex_mem_memwrite   = wr;
      ex_mem_funct3     = f3;
      ex_mem_aluout     = addr;
      ex_mem_store_data = sd;
      dmem_ack          = 1'b0;
      dmem_rdata        = rdata;
      #1;
      for (int c = 0; c < 40 && !done; c++) begin
         if (mem_stall) begin
            stalls++;
            dmem_ack = 1'b0;
            if (dmem_req) begin
               if (reqs == 0) begin
                  chk({tag, " addr"}, dmem_addr, exp_addr);
                  chk({tag, " be"}, 32'(dmem_be), 32'(exp_be));
                  chk({tag, " we"}, 32'(dmem_we), 32'(exp_we));
                  if (chk_wd) chk({tag, " wdata"}, dmem_wdata, exp_wd);
               end
               reqs++;
               dmem_ack = (ack_k >= 0) && (reqs - 1 == ack_k);
            end
            step();
         end else begin
            done = 1'b1;
         end
      end
      dmem_ack = 1'b0;
      #1;
      chk({tag, " reached DONE"}, 32'(done), 32'd1);
      chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
      chk({tag, " req cycles"}, 32'(reqs), 32'(exp_reqs));
      chk({tag, " aluout2"}, aluout2, exp_a2);
      chk({tag, " aluout1"}, aluout1, addr);
      chk({tag, " bus_err"}, 32'(bus_err), 32'(exp_berr));
      chk({tag, " valid"}, 32'(mem_ins_valid), 32'(exp_valid));
      ex_mem_ins_valid = 1'b0;
      step();
      chk({tag, " idle bus_err"}, 32'(bus_err), 32'd0);
      chk({tag, " idle req"}, 32'(dmem_req), 32'd0);
   endtask

   initial begin
      rst               = 1'b0;
      ex_mem_ins_valid  = 1'b1;
      ex_mem_memread    = 1'b1;
      ex_mem_memwrite   = 1'b0;
      ex_mem_funct3     = 3'b010;
      ex_mem_aluout     = 32'h0000_0100;
      ex_mem_store_data = 32'd0;
      dmem_ack          = 1'b0;
      dmem_rdata        = 32'd0;
      step();
      step();
      chk("reset req", 32'(dmem_req), 32'd0);
      chk("reset stall", 32'(mem_stall), 32'd0);
      chk("reset aluout1", aluout1, 32'd0);
      chk("reset valid", 32'(mem_ins_valid), 32'd0);
      chk("reset be", 32'(dmem_be), 32'd0);
      ex_mem_ins_valid = 1'b0;
      #2 rst = 1'b1;
      step();

      do_access("LW", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF,
                4'b1111, 32'h100, 0, 0, 32'h0, 2, 1, 0, 1);
      do_access("LB", 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000, 32'hFFFF_FF80,
                4'b1000, 32'h100, 0, 0, 32'h0, 3, 2, 0, 1);
      do_access("LBU", 1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000, 32'h0000_0080,
                4'b1000, 32'h100, 0, 0, 32'h0, 2, 1, 0, 1);
      do_access("LH", 1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_0000, 32'hFFFF_80FF,
                4'b1100, 32'h100, 0, 0, 32'h0, 2, 1, 0, 1);
      // ack lands on the same cycle the counter hits TIMEOUT: ack wins
      do_access("SH", 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'hFFFF_FFFF, 32'h0,
                4'b1100, 32'h200, 1, 1, 32'hABCDABCD, 5, 4, 0, 1);
      do_access("SB", 0, 1, 3'b000, 32'h301, 32'h0000_0055, 0, 32'h0, 32'h0,
                4'b0010, 32'h300, 1, 1, 32'h55555555, 2, 1, 0, 1);
      do_access("TMO", 1, 0, 3'b010, 32'h400, 32'h0, -1, 32'h1111_1111, 32'h0,
                4'b1111, 32'h400, 0, 0, 32'h0, 5, 4, 1, 0);

      // stray ack while idle
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk("stray ack req", 32'(dmem_req), 32'd0);
      chk("stray ack stall", 32'(mem_stall), 32'd0);
      chk("stray ack bus_err", 32'(bus_err), 32'd0);

      // misaligned LW
      ex_mem_ins_valid = 1'b1;
      ex_mem_memread   = 1'b1;
      ex_mem_memwrite  = 1'b0;
      ex_mem_funct3    = 3'b010;
      ex_mem_aluout    = 32'h101;
      #1;
      chk("misalign fault", 32'(mem_fault), 32'd1);
      chk("misalign valid", 32'(mem_ins_valid), 32'd0);
      chk("misalign stall", 32'(mem_stall), 32'd0);
      step();
      chk("misalign req", 32'(dmem_req), 32'd0);
      // illegal load funct3
      ex_mem_funct3 = 3'b011;
      ex_mem_aluout = 32'h100;
      #1;
      chk("illegal fault", 32'(mem_fault), 32'd1);
      chk("illegal stall", 32'(mem_stall), 32'd0);
      step();
      chk("illegal req", 32'(dmem_req), 32'd0);

      // reset during REQ
      ex_mem_funct3 = 3'b010;
      ex_mem_aluout = 32'h500;
      step();
      step();
      chk("pre-reset req", 32'(dmem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid reset req", 32'(dmem_req), 32'd0);
      chk("mid reset stall", 32'(mem_stall), 32'd0);
      chk("mid reset aluout1", aluout1, 32'd0);
      chk("mid reset valid", 32'(mem_ins_valid), 32'd0);
      ex_mem_ins_valid = 1'b0;
      step();
      #2 rst = 1'b1;
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk("post reset req", 32'(dmem_req), 32'd0);
      chk("post reset stall", 32'(mem_stall), 32'd0);
      do_access("LW2", 1, 0, 3'b010, 32'h500, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D,
                4'b1111, 32'h500, 0, 0, 32'h0, 3, 2, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit between the EX/MEM register and the MEM/WB register. Takes the EX/MEM address, store data and access type, runs a req/ack transaction on the data-memory bus, stalls the front of the pipeline until it completes, and presents `aluout1` (ALU result) and `aluout2` (formatted load data) to the MEM/WB register. It also detects misaligned or illegal accesses and bus timeouts.

## Interface
- `TIMEOUT`, 255: max cycles in REQ without `dmem_ack` before bus error (1..1023).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ex_mem_ins_valid` in 1: EX/MEM holds a valid instruction.
- `ex_mem_memread` in 1: load.
- `ex_mem_memwrite` in 1: store. `memread` has priority if both are set.
- `ex_mem_funct3` in 3: access size and sign.
- `ex_mem_aluout` in 32: effective address / ALU result.
- `ex_mem_store_data` in 32: rs2 value for stores.
- `aluout1` out 32: ALU result to MEM/WB.
- `aluout2` out 32: formatted load data to MEM/WB.
- `mem_ins_valid` out 1: instruction valid into MEM/WB.
- `mem_stall` out 1: hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB is not loaded while high.
- `mem_fault` out 1: misaligned or illegal access, combinational.
- `bus_err` out 1: one-cycle pulse on timeout.
- `dmem_req` out 1: bus request, registered.
- `dmem_we` out 1: write enable, registered.
- `dmem_addr` out 32: word-aligned address (`addr[1:0]=0`), registered.
- `dmem_wdata` out 32: lane-replicated store data, registered.
- `dmem_be` out 4: byte enables, registered.
- `dmem_ack` in 1: transaction complete. Read data is valid in the same cycle.
- `dmem_rdata` in 32: read word.

## Operation
- **Access.** An access is `ex_mem_ins_valid & (memread | memwrite)`.
- **Legal funct3.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Other codes are illegal.
- **Alignment.** Halfword requires `addr[0]=0`; word requires `addr[1:0]=0`.
- **Fault.** A misaligned or illegal access raises `mem_fault=1` and `mem_ins_valid=0`. No bus request is issued and there is no stall.
- **FSM states:** IDLE, REQ, DONE.
- **IDLE.**
  - Legal access: `mem_stall=1`, next state REQ. Register `dmem_req=1`, `dmem_we=memwrite&~memread`, addr, wdata and be.
  - Otherwise the instruction passes through: `mem_stall=0`, `aluout2=0`.
- **REQ.**
  - `mem_stall=1` and the timeout counter increments.
  - On `dmem_ack`: capture formatted load data (0 for stores), drop `dmem_req`, next state DONE.
  - Counter reaching `TIMEOUT`: drop `dmem_req`, pulse `bus_err`, captured data = 0, next state DONE with `mem_ins_valid=0`.
- **DONE.**
  - `mem_stall=0` and `aluout2` = captured data.
  - The same EX/MEM instruction is still on the inputs. It is not relaunched; the pipeline advances at the end of this cycle. Next state IDLE.
- **Load formatting.**
  - Byte is selected by `addr[1:0]`; halfword by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Store formatting.**
  - SB: `wdata={4{b}}`, `be=0001<<addr[1:0]`.
  - SH: `wdata={2{h}}`, `be=0011<<{addr[1],0}`.
  - SW: `be=1111`.
- **Pass-through.** `aluout1 = ex_mem_aluout` in all states. `mem_ins_valid = ex_mem_ins_valid & ~mem_fault`, except on a timeout DONE, where it is 0.
- **Ignored acks.** `dmem_ack` outside REQ is ignored.

## Timing
- **Reset.** While `rst=0`, asynchronously:
  - State returns to IDLE.
  - The timeout counter is cleared.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be` and `bus_err` are 0.
  - `mem_stall`, `mem_fault`, `aluout1`, `aluout2` and `mem_ins_valid` are forced to 0.
- **Reset mid-transaction.** The transaction is abandoned; a later ack is ignored.
- **Latency.** Access seen in IDLE at cycle T. `dmem_req` is high from T+1. If the ack arrives at T+1+k, DONE is at T+2+k.
  - Minimum stall is 2 cycles (T, T+1); a memory instruction occupies at least 3 cycles.
- **Request stability.** `dmem_req` and all bus outputs stay stable until the ack or timeout edge.
- **Ack and timeout together.** If the ack arrives on the cycle the counter hits `TIMEOUT`, the ack wins and `bus_err` stays 0.
- **Back-to-back accesses.** There is always one DONE cycle, then IDLE evaluates the next instruction. The earliest next request is 2 cycles after DONE.
- **Bus error timing.** `bus_err` is high for exactly the DONE cycle following a timeout.

## Test plan
- **LW, immediate ack.** LW addr 0x100, `dmem_ack` on the first REQ cycle with rdata 0xDEADBEEF.
  - Required: stall 2 cycles, DONE `aluout2=0xDEADBEEF`, `dmem_be=1111`, `dmem_addr=0x100`.
- **LB / LBU.** LB addr 0x103 and LBU addr 0x103, rdata 0x80FF_0000.
  - Required: LB gives `aluout2=0xFFFFFF80`; LBU gives `0x00000080`.
- **SH, delayed ack.** SH addr 0x202, data 0x1234ABCD, ack after 3 cycles.
  - Required: `dmem_we=1`, `be=1100`, `wdata=0xABCDABCD`, `addr=0x200`, stall 5 cycles, `aluout2=0`.
- **Misaligned LW.** LW addr 0x101.
  - Required: `mem_fault=1`, `mem_ins_valid=0`, `dmem_req` never set, `mem_stall=0`.
- **Timeout.** `TIMEOUT=4`, no ack.
  - Required: `dmem_req` high 4 cycles, `bus_err` pulse in DONE, `mem_ins_valid=0`.
  - A later stray ack in IDLE has no effect.
- **Reset mid-REQ.** Drop `rst` during REQ.
  - Required: `dmem_req=0` immediately, all outputs 0.
  - After release: IDLE, and the next LW completes normally.
